// File: rtl/noc_pkg.sv
// Shared NoC definitions: channel geometry, flit-type encodings and flit field helpers.
// Used by vc_buffer and vc_out_arbiter.
package noc_pkg;

  localparam int FLIT_WIDTH = 34;
  localparam int N_VIRT_CHN = 3;
  localparam int VC_ID_W    = 2;

  localparam int FT_MSB   = 33;
  localparam int FT_LSB   = 32;
  localparam int SIZE_MSB = 29;
  localparam int SIZE_LSB = 22;

  // The reserved code is carried as a body flit everywhere it matters.
  typedef enum logic [1:0] {
    FT_HEAD = 2'b00,
    FT_BODY = 2'b01,
    FT_RSVD = 2'b10,
    FT_TAIL = 2'b11
  } flit_type_e;

  function automatic flit_type_e flit_type(input logic [FLIT_WIDTH-1:0] flit);
    return flit_type_e'(flit[FT_MSB:FT_LSB]);
  endfunction

  // A head with a non-zero size field opens a wormhole that lasts until the tail.
  function automatic logic is_multi_head(input logic [FLIT_WIDTH-1:0] flit);
    return (flit_type(flit) == FT_HEAD) && (flit[SIZE_MSB:SIZE_LSB] != '0);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i, wrapping,
// reported as a one-hot grant plus its index.
module rr_arbiter #(
  parameter int N_REQ = 3,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_vld_o
);

  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves one unassigned and no latch is inferred.
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!gnt_vld_o && req_i[(int'(ptr_i) + i) % N_REQ]) begin
        gnt_vld_o = 1'b1;
        gnt_o[(int'(ptr_i) + i) % N_REQ] = 1'b1;
        gnt_idx_o = IDX_W'((int'(ptr_i) + i) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/vc_out_arbiter.sv
// Arbitrates per-VC flit streams onto one registered output channel, with wormhole
// locking on multi-flit packets and a one-cycle error pulse on framing violations.
module vc_out_arbiter
  import noc_pkg::*;
(
  input  logic                             clk,
  input  logic                             arst,
  input  logic [N_VIRT_CHN*FLIT_WIDTH-1:0] fdata_i,
  input  logic [N_VIRT_CHN-1:0]            valid_i,
  output logic [N_VIRT_CHN-1:0]            ready_o,
  output logic [FLIT_WIDTH-1:0]            fdata_o,
  output logic [VC_ID_W-1:0]               vc_id_o,
  output logic                             valid_o,
  input  logic                             ready_i,
  output logic                             err_o
);

  logic [FLIT_WIDTH-1:0] fdata_q, fdata_d;
  logic [VC_ID_W-1:0]    vc_id_q, vc_id_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic                  lock_vld_q, lock_vld_d;
  logic [VC_ID_W-1:0]    lock_vc_q, lock_vc_d;
  logic [VC_ID_W-1:0]    rr_ptr_q, rr_ptr_d;

  logic                  stage_free;
  logic [N_VIRT_CHN-1:0] gnt_oh;
  logic [VC_ID_W-1:0]    gnt_idx;
  logic                  gnt_vld;
  logic [N_VIRT_CHN-1:0] lock_oh;
  logic                  xfer;
  logic [VC_ID_W-1:0]    xfer_idx;
  logic [FLIT_WIDTH-1:0] xfer_flit;
  flit_type_e            xfer_type;

  rr_arbiter #(
    .N_REQ (N_VIRT_CHN),
    .IDX_W (VC_ID_W)
  ) u_rr (
    .req_i     (valid_i),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (gnt_oh),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  always_comb begin
    stage_free = !valid_q || ready_i;

    for (int k = 0; k < N_VIRT_CHN; k++) begin
      lock_oh[k] = (lock_vc_q == VC_ID_W'(k));
    end

    // Reset also gates ready_o so no vc_buffer pops a flit that would be lost.
    ready_o = '0;
    if (arst && stage_free) begin
      ready_o = lock_vld_q ? lock_oh : (gnt_vld ? gnt_oh : '0);
    end

    xfer     = |(valid_i & ready_o);
    xfer_idx = lock_vld_q ? lock_vc_q : gnt_idx;

    xfer_flit = '0;
    for (int k = 0; k < N_VIRT_CHN; k++) begin
      if (xfer_idx == VC_ID_W'(k)) xfer_flit = fdata_i[k*FLIT_WIDTH +: FLIT_WIDTH];
    end
    xfer_type = flit_type(xfer_flit);

    fdata_d    = fdata_q;
    vc_id_d    = vc_id_q;
    valid_d    = valid_q;
    err_d      = 1'b0;
    lock_vld_d = lock_vld_q;
    lock_vc_d  = lock_vc_q;
    rr_ptr_d   = rr_ptr_q;

    if (xfer) begin
      fdata_d = xfer_flit;
      vc_id_d = xfer_idx;
      valid_d = 1'b1;
      if (!lock_vld_q) begin
        rr_ptr_d = (xfer_idx == VC_ID_W'(N_VIRT_CHN - 1)) ? '0 : xfer_idx + VC_ID_W'(1);
        err_d    = (xfer_type != FT_HEAD);
        if (is_multi_head(xfer_flit)) begin
          lock_vld_d = 1'b1;
          lock_vc_d  = xfer_idx;
        end
      end else begin
        // A stray head inside a wormhole is flagged but does not re-target the lock.
        err_d = (xfer_type == FT_HEAD);
        if (xfer_type == FT_TAIL) lock_vld_d = 1'b0;
      end
    end else if (stage_free) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      fdata_q    <= '0;
      vc_id_q    <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      lock_vld_q <= 1'b0;
      lock_vc_q  <= '0;
      rr_ptr_q   <= '0;
    end else begin
      fdata_q    <= fdata_d;
      vc_id_q    <= vc_id_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      lock_vld_q <= lock_vld_d;
      lock_vc_q  <= lock_vc_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign fdata_o = fdata_q;
  assign vc_id_o = vc_id_q;
  assign valid_o = valid_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_vc_out_arbiter.sv
// Directed scoreboard bench for vc_out_arbiter: per-VC source queues feed the DUT,
// expected output flits are queued as stimulus is planned and popped on output handshakes.
module tb_vc_out_arbiter;
  import noc_pkg::*;

  localparam int N = N_VIRT_CHN;
  localparam int W = FLIT_WIDTH;

  typedef struct packed {
    logic [VC_ID_W-1:0] vc;
    logic [W-1:0]       flit;
    logic               err;
  } exp_t;

  logic                 clk;
  logic                 arst;
  logic [N*W-1:0]       fdata_i;
  logic [N-1:0]         valid_i;
  logic [N-1:0]         ready_o;
  logic [W-1:0]         fdata_o;
  logic [VC_ID_W-1:0]   vc_id_o;
  logic                 valid_o;
  logic                 ready_i;
  logic                 err_o;

  exp_t       exp_q[$];
  logic [W-1:0] src_q[N][$];
  int         n_checks = 0;
  int         n_fail   = 0;

  vc_out_arbiter dut (
    .clk     (clk),
    .arst    (arst),
    .fdata_i (fdata_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .fdata_o (fdata_o),
    .vc_id_o (vc_id_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .err_o   (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input flit_type_e t, input logic [7:0] size, input int tag);
    return {t, 2'b00, size, 22'(tag)};
  endfunction

  task automatic expect_out(input int vc, input logic [W-1:0] f, input logic e);
    exp_t x;
    x.vc   = VC_ID_W'(vc);
    x.flit = f;
    x.err  = e;
    exp_q.push_back(x);
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      valid_i[k] = (src_q[k].size() != 0);
      fdata_i[k*W +: W] = valid_i[k] ? src_q[k][0] : '0;
    end
  endtask

  // One clock: compare outputs at the falling edge, then advance sources after the rising edge.
  // exp_rdy < 0 only checks that ready_o is at most one-hot.
  task automatic tick(input int exp_rdy);
    logic [N-1:0] xf;
    exp_t e;
    @(negedge clk);
    if (valid_o && ready_i) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $error("FAIL out_unexpected observed=vc%0d expected=none", vc_id_o);
      end else begin
        e = exp_q.pop_front();
        check("out_vc", 64'(vc_id_o), 64'(e.vc));
        check("out_flit", 64'(fdata_o), 64'(e.flit));
        check("out_err", 64'(err_o), 64'(e.err));
      end
    end
    if (exp_rdy >= 0) check("ready_o", 64'(ready_o), 64'(exp_rdy));
    else check("ready_onehot", 64'($countones(ready_o) <= 1), 64'(1));
    xf = valid_i & ready_o;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (xf[k]) begin
        void'(src_q[k].pop_front());
        check("lat_valid", 64'(valid_o), 64'(1));
        check("lat_vc", 64'(vc_id_o), 64'(k));
      end
    end
    drive();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick(-1);
      n++;
    end
    check("drain_done", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    logic [W-1:0] f_h, f_b1, f_b2, f_t, f_s, f_s2, f_bad;

    arst    = 1'b0;
    ready_i = 1'b1;
    valid_i = '0;
    fdata_i = '0;

    // Reset with every VC offering single-flit heads; fairness stream follows.
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < N; k++) begin
        src_q[k].push_back(mk(FT_HEAD, 8'd0, 16 * k + r));
        expect_out(k, mk(FT_HEAD, 8'd0, 16 * k + r), 1'b0);
      end
    end
    drive();
    repeat (3) begin
      @(negedge clk);
      check("rst_valid", 64'(valid_o), 64'(0));
      check("rst_ready", 64'(ready_o), 64'(0));
      check("rst_err", 64'(err_o), 64'(0));
      check("rst_fdata", 64'(fdata_o), 64'(0));
      check("rst_vc", 64'(vc_id_o), 64'(0));
    end
    @(posedge clk);
    #1;
    arst = 1'b1;

    for (int i = 0; i < 6; i++) tick(1 << (i % 3));
    drain(4);

    // Wormhole on VC1 with VC0/VC2 contending.
    f_h  = mk(FT_HEAD, 8'd3, 256);
    f_b1 = mk(FT_BODY, 8'd0, 257);
    f_b2 = mk(FT_RSVD, 8'd0, 258);
    f_t  = mk(FT_TAIL, 8'd0, 259);
    f_s  = mk(FT_HEAD, 8'd0, 260);
    f_s2 = mk(FT_HEAD, 8'd0, 261);
    src_q[0].push_back(f_s);
    src_q[0].push_back(f_s2);
    src_q[1].push_back(f_h);
    src_q[1].push_back(f_b1);
    src_q[1].push_back(f_b2);
    src_q[1].push_back(f_t);
    src_q[2].push_back(mk(FT_HEAD, 8'd0, 262));
    expect_out(0, f_s, 1'b0);
    expect_out(1, f_h, 1'b0);
    expect_out(1, f_b1, 1'b0);
    expect_out(1, f_b2, 1'b0);
    expect_out(1, f_t, 1'b0);
    expect_out(2, mk(FT_HEAD, 8'd0, 262), 1'b0);
    expect_out(0, f_s2, 1'b0);
    drive();
    tick(1);
    tick(2);
    tick(2);
    tick(2);
    tick(2);
    tick(4);
    tick(1);
    drain(4);

    // Backpressure in the middle of a VC1 packet.
    f_h  = mk(FT_HEAD, 8'd3, 512);
    f_b1 = mk(FT_BODY, 8'd0, 513);
    f_b2 = mk(FT_BODY, 8'd0, 514);
    f_t  = mk(FT_TAIL, 8'd0, 515);
    src_q[1].push_back(f_h);
    src_q[1].push_back(f_b1);
    src_q[1].push_back(f_b2);
    src_q[1].push_back(f_t);
    expect_out(1, f_h, 1'b0);
    expect_out(1, f_b1, 1'b0);
    expect_out(1, f_b2, 1'b0);
    expect_out(1, f_t, 1'b0);
    drive();
    tick(2);
    tick(2);
    ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(0);
      check("bp_fdata", 64'(fdata_o), 64'(f_b1));
      check("bp_vc", 64'(vc_id_o), 64'(1));
    end
    ready_i = 1'b1;
    tick(2);
    tick(2);
    drain(4);

    // Body while unlocked: forwarded with a single-cycle error pulse.
    f_bad = mk(FT_BODY, 8'd0, 768);
    src_q[0].push_back(f_bad);
    expect_out(0, f_bad, 1'b1);
    drive();
    tick(1);
    drain(3);
    check("err_one_cycle", 64'(err_o), 64'(0));

    // Head while locked on VC2: flagged, lock stays on VC2 so VC0 waits for the tail.
    f_h   = mk(FT_HEAD, 8'd2, 1024);
    f_bad = mk(FT_HEAD, 8'd0, 1025);
    f_t   = mk(FT_TAIL, 8'd0, 1026);
    f_s   = mk(FT_HEAD, 8'd0, 1027);
    src_q[2].push_back(f_h);
    src_q[2].push_back(f_bad);
    src_q[2].push_back(f_t);
    src_q[0].push_back(f_s);
    expect_out(2, f_h, 1'b0);
    expect_out(2, f_bad, 1'b1);
    expect_out(2, f_t, 1'b0);
    expect_out(0, f_s, 1'b0);
    drive();
    tick(4);
    tick(4);
    tick(4);
    tick(1);
    drain(4);

    // Reset after a VC2 multi-flit head: lock and held flit are dropped.
    f_h = mk(FT_HEAD, 8'd2, 1280);
    f_s = mk(FT_HEAD, 8'd0, 1281);
    src_q[2].push_back(f_h);
    src_q[2].push_back(mk(FT_BODY, 8'd0, 1282));
    src_q[2].push_back(mk(FT_TAIL, 8'd0, 1283));
    src_q[0].push_back(f_s);
    expect_out(2, f_h, 1'b0);
    drive();
    tick(4);
    arst = 1'b0;
    #1;
    check("mid_rst_valid", 64'(valid_o), 64'(0));
    check("mid_rst_ready", 64'(ready_o), 64'(0));
    exp_q.delete();
    expect_out(0, f_s, 1'b0);
    tick(0);
    tick(0);
    arst = 1'b1;
    tick(1);
    src_q[2].delete();
    drive();
    drain(4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vc_out_arbiter.md
Name: vc_out_arbiter

Overview:
- Downstream neighbour of vc_buffer in the router input path. Takes the per-VC flit streams out of N vc_buffer instances and arbitrates them onto one physical output flit channel towards the switch/link.
- Wormhole packet locking: once a multi-flit packet's head wins, that VC holds the channel until its tail flit transfers.
- One registered output stage with full-throughput valid/ready, so flit latency through the block is exactly 1 cycle.

Parameters:
- N_VIRT_CHN, 3, number of virtual channels, legal range 2..4.
- FLIT_WIDTH, 34, flit width in bits. Bits [33:32] are the flit type; bits [29:22] are the packet size field.
- VC_ID_W, 2, width of the VC identifier.

Ports:
- clk  in  1  single clock, rising edge.
- arst  in  1  asynchronous reset, active-low.
- fdata_i  in  N_VIRT_CHN*FLIT_WIDTH  flits from each vc_buffer; VC k occupies bits [k*FLIT_WIDTH +: FLIT_WIDTH].
- valid_i  in  N_VIRT_CHN  per-VC flit valid, from vc_buffer valid_o.
- ready_o  out  N_VIRT_CHN  per-VC accept, to vc_buffer ready_i.
- fdata_o  out  FLIT_WIDTH  registered output flit.
- vc_id_o  out  VC_ID_W  VC index of fdata_o.
- valid_o  out  1  output flit valid.
- ready_i  in  1  downstream accept.
- err_o  out  1  one-cycle pulse on a protocol violation.

Behaviour:
- Flit types (from the package):
  - HEAD = 2'b00, BODY = 2'b01, TAIL = 2'b11; 2'b10 is reserved and treated as BODY.
  - A HEAD with size [29:22] != 0 is multi-flit. A HEAD with size == 0 is a single-flit packet and takes no lock.
- Reset (arst low, asynchronous):
  - valid_o=0, fdata_o=0, vc_id_o=0, err_o=0.
  - lock_vld=0, lock_vc=0, rr_ptr=0.
  - ready_o is all zeros while arst is low.
  - Asserting reset mid-packet drops the lock and any held flit; no recovery beyond that.
- Output stage:
  - stage_free = !valid_o || ready_i.
  - Transfer on input VC k happens when valid_i[k] && ready_o[k]. On a transfer, the flit and k are loaded into fdata_o/vc_id_o on the next edge and valid_o=1.
  - If stage_free and no input transfers, valid_o clears. If !stage_free, the output registers hold.
  - Back-to-back transfers at one flit per cycle are sustained while ready_i=1.
- Arbitration, unlocked:
  - Grant goes to the first VC with valid_i set, scanning from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, …, N_VIRT_CHN-1, 0, …).
  - ready_o is one-hot on the granted VC when stage_free, else 0. At most one ready_o bit is ever high.
  - After a transfer from VC g: rr_ptr = (g+1) mod N_VIRT_CHN.
  - If that flit is a multi-flit HEAD: lock_vld=1, lock_vc=g.
- Arbitration, locked:
  - ready_o[lock_vc] = stage_free; every other bit is 0.
  - rr_ptr is frozen.
  - A TAIL transfer from lock_vc clears lock_vld on the same edge. The next cycle arbitrates from the updated rr_ptr.
- Errors: err_o pulses for one cycle (registered) on any of these transfers; the flit is still forwarded and lock state is updated normally.
  - BODY or TAIL while unlocked.
  - HEAD while locked on lock_vc; in this case the lock stays and lock_vc is unchanged.
- Simultaneous events:
  - ready_i=1 with a new input transfer in the same cycle: the output is replaced without a bubble.
  - A valid_i deassertion by a non-granted VC has no effect.
  - Inputs change combinationally only through ready_o; there is no combinational path from valid_i to valid_o.

Decomposition:
- Shared package noc_pkg:
  - FLIT_WIDTH, N_VIRT_CHN, VC_ID_W.
  - Flit type encodings HEAD/BODY/TAIL.
  - Packet size field slice constants (29:22) and a flit-type field slice (33:32).
  - The same package is used by vc_buffer.
- One natural sub-module: rr_arbiter. Combinational round-robin over req[N_VIRT_CHN] and ptr, producing a one-hot grant and its index. The lock, pointer update and output stage stay in vc_out_arbiter.

Test Plan:
- Reset: hold arst=0 for 3 cycles with all valid_i=1 → valid_o=0, ready_o=3'b000, err_o=0. Release → the first grant goes to VC0 (rr_ptr=0).
- Round-robin fairness: VC0..2 all stream single-flit HEADs (size=0), ready_i=1 → vc_id_o sequence 0,1,2,0,1,2; one flit per cycle; output 1 cycle after each transfer.
- Wormhole lock: VC1 sends HEAD size=3, BODY, BODY, TAIL while VC0 and VC2 stay valid → 4 consecutive outputs with vc_id_o=1 and ready_o[0]=ready_o[2]=0 throughout. The next grant goes to VC2.
- Backpressure: ready_i=0 for 5 cycles mid-packet → fdata_o/vc_id_o stable, ready_o=0. Release → the stream resumes with no lost or duplicated flit.
- Protocol error: BODY flit on VC0 while unlocked → err_o=1 for exactly one cycle, flit forwarded with vc_id_o=0. A HEAD on the locked VC also pulses err_o and leaves lock_vc unchanged.
- Reset mid-packet: arst asserted after a HEAD size=2 on VC2 → lock cleared. After release, VC0 is granted first even though VC2 is still valid.
